shift_seq: RTL

Multi-cycle shift sequencer for the ALU shift path. It accepts one shift request at a time over a valid/ready handshake and drives a 1-bit-per-cycle shift datapath. The signed/arithmetic selection for each step comes from a decode of the 4-bit ALU operation code. The result is held on a valid/ready output until the consumer (writeback/stall logic) takes it.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 20 ++
 rtl/shift_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared opcodes, state encoding and decode helper
// for the ALU shift sequencer.
package shift_pkg;

  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift step: left, logical right,
// or arithmetic right with the current MSB as fill.
module shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             i_left,
  input  logic             i_athi,
  output logic [WIDTH-1:0] acc_nxt
);

  always_comb begin
    acc_nxt = acc;
    unique case (1'b1)
      i_left:  acc_nxt = {acc[WIDTH-2:0], 1'b0};
      default: acc_nxt = {i_athi & acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: accepts one request,
// shifts one bit per cycle, holds the result until taken.
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_oper,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal,
  output logic             o_busy
);

  shift_state_e     state_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [AMT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic             ill_q;
  logic             unused_opb;

  // Amounts wrap modulo WIDTH: upper operand bits are ignored.
  assign unused_opb = ^i_opb[WIDTH-1:AMT_W];

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc    (acc),
    .i_left (op_q == OP_SLL),
    .i_athi (op_q == OP_SRA),
    .acc_nxt(acc_nxt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            acc     <= i_opa;
            op_q    <= i_oper;
            state_q <= SHIFT;
            if (is_shift_op(i_oper)) begin
              cnt   <= i_opb[AMT_W-1:0];
              ill_q <= 1'b0;
            end else begin
              cnt   <= '0;
              ill_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            state_q <= DONE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - AMT_W'(1);
          end
        end
        DONE: begin
          if (i_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_busy    = (state_q == SHIFT) || (state_q == DONE);
  assign o_result  = acc;
  assign o_illegal = ill_q;

endmodule
